// File: rtl/dp_ram_param.sv
// Simple dual-port RAM with one write port and one read port on a single clock.
// Provides per-byte write enables, a 1- or 2-cycle registered read with r_valid,
// a selectable read/write collision policy, and an init sweep that fills every
// word with INIT_VALUE after reset or when requested.
module dp_ram_param #(
    parameter int unsigned           DATA_WIDTH     = 8,
    parameter int unsigned           DEPTH          = 512,
    parameter int unsigned           ADDR_WIDTH     = 9,
    parameter int unsigned           BE_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned           RD_LATENCY     = 1,
    parameter int unsigned           COLLISION_MODE = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_req,
    input  logic                  w_enable,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [BE_WIDTH-1:0]   w_be,
    input  logic                  r_enable,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  init_busy
);

    localparam int unsigned LAST_ADDR = DEPTH - 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   sweep_addr_q;
    logic                    sweep_last_c;
    logic                    sweep_we_c;
    logic                    wr_accept_c;
    logic                    rd_accept_c;
    logic                    w_in_range_c;
    logic                    r_in_range_c;
    logic                    mem_we_c;
    logic [ADDR_WIDTH-1:0]   mem_waddr_c;
    logic [DATA_WIDTH-1:0]   mem_wdata_c;
    logic [DATA_WIDTH-1:0]   w_old_c;
    logic [DATA_WIDTH-1:0]   w_merged_c;
    logic [DATA_WIDTH-1:0]   r_word_c;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign sweep_last_c = (sweep_addr_q == ADDR_WIDTH'(LAST_ADDR));
    assign w_in_range_c = (32'(w_addr) < DEPTH);
    assign r_in_range_c = (32'(r_addr) < DEPTH);
    assign w_old_c      = mem[w_addr];

    // State register: reset always lands in the init sweep
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state: sweep ends on its last word, init_req restarts it from RUN
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_INIT: if (sweep_last_c) state_nxt = ST_RUN;
            ST_RUN:  if (init_req)     state_nxt = ST_INIT;
            default: state_nxt = ST_INIT;
        endcase
    end

    // Control decode: sweep owns the write port in INIT, user ports only in RUN
    always_comb begin
        sweep_we_c  = 1'b0;
        wr_accept_c = 1'b0;
        rd_accept_c = 1'b0;
        case (state_q)
            ST_INIT: sweep_we_c = 1'b1;
            ST_RUN: begin
                wr_accept_c = w_enable && w_in_range_c && (|w_be);
                rd_accept_c = r_enable;
            end
            default: sweep_we_c = 1'b1;
        endcase
        mem_we_c    = rst_n && (sweep_we_c || wr_accept_c);
        mem_waddr_c = sweep_we_c ? sweep_addr_q : w_addr;
        mem_wdata_c = sweep_we_c ? INIT_VALUE : w_merged_c;
    end

    // Byte-lane merge of incoming write data over the currently stored word
    always_comb begin
        w_merged_c = w_old_c;
        for (int unsigned i = 0; i < BE_WIDTH; i++) begin
            if (w_be[i]) begin
                w_merged_c[8*i +: 8] = w_data[8*i +: 8];
            end
        end
    end

    // Read word selection: out-of-range reads give zero, collision per mode
    always_comb begin
        r_word_c = '0;
        if (r_in_range_c) begin
            if ((COLLISION_MODE == 1) && wr_accept_c && (w_addr == r_addr)) begin
                r_word_c = w_merged_c;
            end else begin
                r_word_c = mem[r_addr];
            end
        end
    end

    // Sweep address: advances while sweeping, parked at zero otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sweep_addr_q <= '0;
        end else if (sweep_we_c && !sweep_last_c) begin
            sweep_addr_q <= sweep_addr_q + ADDR_WIDTH'(1);
        end else begin
            sweep_addr_q <= '0;
        end
    end

    // Storage array: contents are not reset, only written by sweep or user
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Busy flag tracks the state the FSM is entering
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_busy <= 1'b1;
        end else begin
            init_busy <= (state_nxt == ST_INIT);
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  s1_valid_q;
            logic [DATA_WIDTH-1:0] s1_data_q;

            // Two-stage read: memory stage then output stage, data held when idle
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_valid_q <= 1'b0;
                    s1_data_q  <= '0;
                    r_valid    <= 1'b0;
                    r_data     <= '0;
                end else begin
                    s1_valid_q <= rd_accept_c;
                    if (rd_accept_c) begin
                        s1_data_q <= r_word_c;
                    end
                    r_valid <= s1_valid_q;
                    if (s1_valid_q) begin
                        r_data <= s1_data_q;
                    end
                end
            end
        end else begin : g_lat1
            // Single-stage read, data held when no new result
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else begin
                    r_valid <= rd_accept_c;
                    if (rd_accept_c) begin
                        r_data <= r_word_c;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_dp_ram_param.sv
// Bench for dp_ram_param: two instances sharing stimulus, one read-first with
// latency 1 and full depth, one write-first with latency 2 and a partial depth,
// each compared against a word-array reference model.
module tb_dp_ram_param;

    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 9;
    localparam int unsigned DEP_A  = 512;
    localparam int unsigned DEP_B  = 300;
    localparam logic [31:0] INIT_A = 32'h0000_0000;
    localparam logic [31:0] INIT_B = 32'hC3C3_5A5A;

    logic          clk;
    logic          rst_n;
    logic          init_req;
    logic          w_enable;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [3:0]    w_be;
    logic          r_enable;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data_a, r_data_b;
    logic          r_valid_a, r_valid_b;
    logic          busy_a, busy_b;

    int n_checks;
    int n_errs;

    dp_ram_param #(
        .DATA_WIDTH(DW), .DEPTH(DEP_A), .ADDR_WIDTH(AW),
        .RD_LATENCY(1), .COLLISION_MODE(0), .INIT_VALUE(INIT_A)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .init_req(init_req),
        .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
        .r_enable(r_enable), .r_addr(r_addr),
        .r_data(r_data_a), .r_valid(r_valid_a), .init_busy(busy_a)
    );

    dp_ram_param #(
        .DATA_WIDTH(DW), .DEPTH(DEP_B), .ADDR_WIDTH(AW),
        .RD_LATENCY(2), .COLLISION_MODE(1), .INIT_VALUE(INIT_B)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .init_req(init_req),
        .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
        .r_enable(r_enable), .r_addr(r_addr),
        .r_data(r_data_b), .r_valid(r_valid_b), .init_busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: per instance word array, busy countdown, result schedule
    int unsigned m_dep [2];
    int          m_lat [2];
    int          m_mode [2];
    logic [31:0] m_init [2];
    logic [31:0] m_mem [2][512];
    int          m_busy_left [2];
    logic        m_slot_v [2][4];
    logic [31:0] m_slot_d [2][4];
    logic        m_valid [2];
    logic [31:0] m_data [2];
    int          cyc;

    function automatic logic o_valid(input int d);
        return (d == 0) ? r_valid_a : r_valid_b;
    endfunction

    function automatic logic [31:0] o_data(input int d);
        return (d == 0) ? r_data_a : r_data_b;
    endfunction

    function automatic logic o_busy(input int d);
        return (d == 0) ? busy_a : busy_b;
    endfunction

    task automatic model_edge();
        logic [31:0] merged;
        logic [31:0] rd;
        int          slot;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_busy_left[d] = int'(m_dep[d]);
                for (int s = 0; s < 4; s++) m_slot_v[d][s] = 1'b0;
                m_valid[d] = 1'b0;
                m_data[d]  = 32'h0;
            end else begin
                if (m_busy_left[d] == 0) begin
                    merged = m_mem[d][w_addr];
                    for (int i = 0; i < 4; i++)
                        if (w_be[i]) merged[8*i +: 8] = w_data[8*i +: 8];
                    if (r_enable) begin
                        if (r_addr >= m_dep[d]) rd = 32'h0;
                        else if (m_mode[d] == 1 && w_enable && w_addr == r_addr) rd = merged;
                        else rd = m_mem[d][r_addr];
                        slot = (cyc + m_lat[d] - 1) % 4;
                        m_slot_v[d][slot] = 1'b1;
                        m_slot_d[d][slot] = rd;
                    end
                    if (w_enable && w_addr < m_dep[d]) m_mem[d][w_addr] = merged;
                    if (init_req) m_busy_left[d] = int'(m_dep[d]);
                end else begin
                    m_busy_left[d]--;
                    if (m_busy_left[d] == 0)
                        for (int a = 0; a < int'(m_dep[d]); a++) m_mem[d][a] = m_init[d];
                end
                m_valid[d] = m_slot_v[d][cyc % 4];
                if (m_slot_v[d][cyc % 4]) m_data[d] = m_slot_d[d][cyc % 4];
                m_slot_v[d][cyc % 4] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        init_req = 1'b0;
        w_enable = 1'b0;
        r_enable = 1'b0;
        w_addr   = '0;
        r_addr   = '0;
        w_data   = '0;
        w_be     = '0;
    endtask

    task automatic drive_random(input bit en);
        w_enable = en ? 1'($urandom) : 1'b0;
        r_enable = en ? 1'($urandom) : 1'b0;
        w_addr   = AW'($urandom_range(0, 511));
        r_addr   = AW'($urandom_range(0, 511));
        w_data   = DW'($urandom);
        w_be     = 4'($urandom);
    endtask

    task automatic do_write(input int addr, input logic [31:0] data, input logic [3:0] be);
        drive_idle();
        w_enable = 1'b1;
        w_addr   = AW'(addr);
        w_data   = data;
        w_be     = be;
        step();
        drive_idle();
    endtask

    task automatic test_reset();
        int cnt [2];
        int rv_bad [2];
        int exp_cnt [2];
        int guard;
        exp_cnt = '{512, 300};
        rst_n = 1'b0;
        drive_idle();
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_busy(d) !== 1'b1) begin
                n_errs++; $display("FAIL reset_busy: dut%0d got %b want 1", d, o_busy(d));
            end
            n_checks++;
            if (o_valid(d) !== 1'b0) begin
                n_errs++; $display("FAIL reset_valid: dut%0d got %b want 0", d, o_valid(d));
            end
            n_checks++;
            if (o_data(d) !== 32'h0) begin
                n_errs++; $display("FAIL reset_data: dut%0d got %h want 0", d, o_data(d));
            end
        end
        cnt = '{0, 0};
        rv_bad = '{0, 0};
        guard = 0;
        rst_n = 1'b1;
        while ((busy_a || busy_b) && guard < 1000) begin
            for (int d = 0; d < 2; d++) begin
                if (o_busy(d)) begin
                    cnt[d]++;
                    if (o_valid(d) !== 1'b0) rv_bad[d]++;
                end
            end
            drive_random(busy_a && busy_b);
            step();
            guard++;
        end
        drive_idle();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (cnt[d] != exp_cnt[d]) begin
                n_errs++; $display("FAIL reset_busy_len: dut%0d got %0d want %0d", d, cnt[d], exp_cnt[d]);
            end
            n_checks++;
            if (rv_bad[d] != 0) begin
                n_errs++; $display("FAIL busy_rvalid: dut%0d got %0d pulses want 0", d, rv_bad[d]);
            end
        end
    endtask

    task automatic test_init_readback();
        int va;
        va = 0;
        for (int a = 0; a < 514; a++) begin
            r_enable = (a < 512);
            r_addr   = AW'(a);
            step();
            if (r_valid_a) va++;
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (o_valid(d) !== m_valid[d] || o_data(d) !== m_data[d]) begin
                    n_errs++;
                    $display("FAIL init_readback: dut%0d addr %0d got v=%b d=%h want v=%b d=%h",
                             d, a, o_valid(d), o_data(d), m_valid[d], m_data[d]);
                end
            end
        end
        drive_idle();
        n_checks++;
        if (va != 512) begin
            n_errs++; $display("FAIL readback_count: dut0 got %0d results want 512", va);
        end
    endtask

    task automatic test_byte_enable();
        do_write(5, 32'hAABB_CCDD, 4'hF);
        do_write(5, 32'h1122_3344, 4'b0101);
        do_write(5, 32'hFFFF_FFFF, 4'b0000);
        r_enable = 1'b1; r_addr = AW'(5);
        step();
        drive_idle();
        n_checks++;
        if (r_valid_a !== 1'b1 || r_data_a !== 32'hAA22_CC44) begin
            n_errs++; $display("FAIL be_lat1: got v=%b d=%h want v=1 d=aa22cc44", r_valid_a, r_data_a);
        end
        n_checks++;
        if (r_valid_b !== 1'b0) begin
            n_errs++; $display("FAIL be_lat2_early: got v=%b want 0", r_valid_b);
        end
        step();
        n_checks++;
        if (r_valid_a !== 1'b0 || r_data_a !== 32'hAA22_CC44) begin
            n_errs++; $display("FAIL be_hold: got v=%b d=%h want v=0 d=aa22cc44", r_valid_a, r_data_a);
        end
        n_checks++;
        if (r_valid_b !== 1'b1 || r_data_b !== 32'hAA22_CC44) begin
            n_errs++; $display("FAIL be_lat2: got v=%b d=%h want v=1 d=aa22cc44", r_valid_b, r_data_b);
        end
        do_write(400, 32'h0000_0077, 4'hF);
        r_enable = 1'b1; r_addr = AW'(400);
        step();
        drive_idle();
        n_checks++;
        if (r_valid_a !== 1'b1 || r_data_a !== 32'h0000_0077) begin
            n_errs++; $display("FAIL addr400_a: got v=%b d=%h want v=1 d=77", r_valid_a, r_data_a);
        end
        step();
        n_checks++;
        if (r_valid_b !== 1'b1 || r_data_b !== 32'h0) begin
            n_errs++; $display("FAIL out_of_range_b: got v=%b d=%h want v=1 d=0", r_valid_b, r_data_b);
        end
    endtask

    task automatic test_collision();
        do_write(7, 32'h0000_0012, 4'hF);
        w_enable = 1'b1; w_addr = AW'(7); w_data = 32'h0000_0034; w_be = 4'hF;
        r_enable = 1'b1; r_addr = AW'(7);
        step();
        drive_idle();
        n_checks++;
        if (r_data_a !== 32'h0000_0012) begin
            n_errs++; $display("FAIL coll_read_first: got %h want 00000012", r_data_a);
        end
        step();
        n_checks++;
        if (r_valid_b !== 1'b1 || r_data_b !== 32'h0000_0034) begin
            n_errs++; $display("FAIL coll_write_first: got v=%b d=%h want v=1 d=00000034", r_valid_b, r_data_b);
        end
        w_enable = 1'b1; w_addr = AW'(7); w_data = 32'hCAFE_BE99; w_be = 4'b1100;
        r_enable = 1'b1; r_addr = AW'(7);
        step();
        drive_idle();
        n_checks++;
        if (r_data_a !== 32'h0000_0034) begin
            n_errs++; $display("FAIL coll_partial_rf: got %h want 00000034", r_data_a);
        end
        step();
        n_checks++;
        if (r_data_b !== 32'hCAFE_0034) begin
            n_errs++; $display("FAIL coll_partial_wf: got %h want cafe0034", r_data_b);
        end
        w_enable = 1'b1; w_addr = AW'(8); w_data = 32'h0000_0055; w_be = 4'hF;
        r_enable = 1'b1; r_addr = AW'(7);
        step();
        drive_idle();
        n_checks++;
        if (r_data_a !== 32'hCAFE_0034) begin
            n_errs++; $display("FAIL diff_addr_a: got %h want cafe0034", r_data_a);
        end
        step();
        n_checks++;
        if (r_data_b !== 32'hCAFE_0034) begin
            n_errs++; $display("FAIL diff_addr_b: got %h want cafe0034", r_data_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        logic        ev;
        logic [31:0] ed;
        for (int i = 0; i < 4; i++) begin
            vals[i] = DW'($urandom);
            do_write(i, vals[i], 4'hF);
        end
        for (int k = 0; k < 7; k++) begin
            r_enable = (k < 4);
            r_addr   = AW'(k);
            step();
            ev = (k < 4);
            ed = vals[(k < 4) ? k : 3];
            n_checks++;
            if (r_valid_a !== ev || r_data_a !== ed) begin
                n_errs++; $display("FAIL b2b_lat1: k=%0d got v=%b d=%h want v=%b d=%h", k, r_valid_a, r_data_a, ev, ed);
            end
            ev = (k >= 1 && k <= 4);
            n_checks++;
            if (r_valid_b !== ev) begin
                n_errs++; $display("FAIL b2b_lat2_valid: k=%0d got %b want %b", k, r_valid_b, ev);
            end
            if (k >= 1) begin
                ed = vals[(k - 1 < 3) ? k - 1 : 3];
                n_checks++;
                if (r_data_b !== ed) begin
                    n_errs++; $display("FAIL b2b_lat2_data: k=%0d got %h want %h", k, r_data_b, ed);
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_init_req();
        int cnt [2];
        int exp_cnt [2];
        int guard;
        exp_cnt = '{512, 300};
        do_write(3, 32'h0000_005A, 4'hF);
        r_enable = 1'b1; r_addr = AW'(3);
        step();
        drive_idle();
        n_checks++;
        if (r_valid_a !== 1'b1 || r_data_a !== 32'h0000_005A) begin
            n_errs++; $display("FAIL pre_init_read: got v=%b d=%h want v=1 d=5a", r_valid_a, r_data_a);
        end
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        n_checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1 || r_valid_a !== 1'b0) begin
            n_errs++; $display("FAIL init_enter: got busy=%b%b va=%b want busy=11 va=0", busy_a, busy_b, r_valid_a);
        end
        n_checks++;
        if (r_valid_b !== 1'b1 || r_data_b !== 32'h0000_005A) begin
            n_errs++; $display("FAIL inflight_lat2: got v=%b d=%h want v=1 d=5a", r_valid_b, r_data_b);
        end
        cnt = '{0, 0};
        guard = 0;
        while ((busy_a || busy_b) && guard < 1000) begin
            for (int d = 0; d < 2; d++) if (o_busy(d)) cnt[d]++;
            drive_random(busy_a && busy_b);
            init_req = (guard == 100);
            step();
            guard++;
        end
        drive_idle();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (cnt[d] != exp_cnt[d]) begin
                n_errs++; $display("FAIL init_req_busy_len: dut%0d got %0d want %0d", d, cnt[d], exp_cnt[d]);
            end
        end
        r_enable = 1'b1; r_addr = AW'(3);
        step();
        drive_idle();
        n_checks++;
        if (r_valid_a !== 1'b1 || r_data_a !== INIT_A) begin
            n_errs++; $display("FAIL reinit_a: got v=%b d=%h want v=1 d=%h", r_valid_a, r_data_a, INIT_A);
        end
        step();
        n_checks++;
        if (r_valid_b !== 1'b1 || r_data_b !== INIT_B) begin
            n_errs++; $display("FAIL reinit_b: got v=%b d=%h want v=1 d=%h", r_valid_b, r_data_b, INIT_B);
        end
    endtask

    task automatic test_reset_mid();
        int cnt [2];
        int exp_cnt [2];
        int guard;
        exp_cnt = '{512, 300};
        r_enable = 1'b1; r_addr = AW'(3);
        step();
        drive_idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_valid(d) !== 1'b0 || o_data(d) !== 32'h0 || o_busy(d) !== 1'b1) begin
                n_errs++; $display("FAIL flush: dut%0d got v=%b d=%h busy=%b want v=0 d=0 busy=1",
                                   d, o_valid(d), o_data(d), o_busy(d));
            end
        end
        repeat (200) step();
        n_checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            n_errs++; $display("FAIL mid_sweep_busy: got %b%b want 11", busy_a, busy_b);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cnt = '{0, 0};
        guard = 0;
        while ((busy_a || busy_b) && guard < 1000) begin
            for (int d = 0; d < 2; d++) if (o_busy(d)) cnt[d]++;
            step();
            guard++;
        end
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (cnt[d] != exp_cnt[d]) begin
                n_errs++; $display("FAIL restart_busy_len: dut%0d got %0d want %0d", d, cnt[d], exp_cnt[d]);
            end
        end
    endtask

    task automatic test_random();
        int sel;
        for (int c = 0; c < 3000; c++) begin
            init_req = ($urandom_range(0, 599) == 0);
            w_enable = 1'($urandom);
            r_enable = 1'($urandom);
            w_data   = DW'($urandom);
            w_be     = 4'($urandom);
            sel = $urandom_range(0, 7);
            if (sel < 6) w_addr = AW'($urandom_range(0, 15));
            else if (sel == 6) w_addr = AW'($urandom_range(300, 307));
            else w_addr = AW'($urandom_range(508, 511));
            r_addr = ($urandom_range(0, 3) == 0) ? w_addr : AW'($urandom_range(0, 15));
            step();
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (o_busy(d) !== (m_busy_left[d] > 0) || o_valid(d) !== m_valid[d] || o_data(d) !== m_data[d]) begin
                    n_errs++;
                    $display("FAIL random: dut%0d cyc %0d got busy=%b v=%b d=%h want busy=%b v=%b d=%h",
                             d, c, o_busy(d), o_valid(d), o_data(d), (m_busy_left[d] > 0), m_valid[d], m_data[d]);
                end
            end
        end
        drive_idle();
    endtask

    initial begin
        n_checks = 0;
        n_errs   = 0;
        cyc      = 0;
        m_dep    = '{DEP_A, DEP_B};
        m_lat    = '{1, 2};
        m_mode   = '{0, 1};
        m_init   = '{INIT_A, INIT_B};
        for (int d = 0; d < 2; d++) begin
            m_busy_left[d] = 0;
            m_valid[d] = 1'b0;
            m_data[d]  = 32'h0;
            for (int s = 0; s < 4; s++) m_slot_v[d][s] = 1'b0;
        end
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        test_reset();
        test_init_readback();
        test_byte_enable();
        test_collision();
        test_back_to_back();
        test_init_req();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
